// File: rtl/fft_result_serializer.sv
// fft_result_serializer: buffers 64-bit FFT result words in a 2-entry FIFO
// and streams them out one byte at a time toward the FT245 write path.
// Optional build macro FRAME_MARKER_EN: when defined, the marker pair
// 0xA5, 0x5A is emitted before the first word after reset and before the
// first word following every completed TLAST word.
module fft_result_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] FFT_DATA_IN,
  input  logic        FFT_IN_VALID,
  input  logic        FFT_IN_TLAST,
  output logic        RESUALT_READY,
  output logic [7:0]  BYTE_OUT,
  output logic        BYTE_VALID,
  input  logic        BYTE_READY,
  output logic        FRAME_DONE,
  output logic        BUSY
);

`ifdef FRAME_MARKER_EN
  localparam bit MARKER_EN = 1'b1;
`else
  localparam bit MARKER_EN = 1'b0;
`endif

  localparam logic [7:0] MARK0_BYTE = 8'hA5;
  localparam logic [7:0] MARK1_BYTE = 8'h5A;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK0 = 2'd1,
    S_MARK1 = 2'd2,
    S_DATA  = 2'd3
  } state_t;

  // input buffer
  fifo_entry_t [1:0] fifo_mem;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  fifo_entry_t       head;

  // serializer
  state_t      state, state_n;
  logic [63:0] shreg;
  logic [63:0] shreg_shifted;
  logic [2:0]  byte_idx;
  logic        cur_last;
  logic        marker_due, marker_n;
  logic        done_n;
  logic        shift;
  logic [7:0]  cur_byte;

  assign fifo_empty    = (count == 2'd0);
  assign RESUALT_READY = (count < 2'd2);
  assign push          = FFT_IN_VALID & RESUALT_READY;
  assign head          = fifo_mem[rd_ptr];
  assign BUSY          = !fifo_empty || (state != S_IDLE);

  // byte order is fixed at elaboration: either drain from the bottom or the top
  assign cur_byte      = LSB_FIRST ? shreg[7:0] : shreg[63:56];
  assign shreg_shifted = LSB_FIRST ? {8'h00, shreg[63:8]} : {shreg[55:0], 8'h00};

  // FIFO storage: payload needs no reset, occupancy guards every read
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {FFT_IN_TLAST, FFT_DATA_IN};
  end

  // FIFO pointers and occupancy; push+pop together keeps count unchanged
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // serializer state, shift register, byte index and frame pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      shreg      <= 64'h0;
      byte_idx   <= 3'd0;
      cur_last   <= 1'b0;
      marker_due <= 1'b1;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_n;
      marker_due <= marker_n;
      FRAME_DONE <= done_n;
      if (pop) begin
        shreg    <= head.data;
        cur_last <= head.last;
        byte_idx <= 3'd0;
      end else if (shift) begin
        shreg    <= shreg_shifted;
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  // next state, load/shift strobes and byte output
  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    shift      = 1'b0;
    marker_n   = marker_due;
    done_n     = 1'b0;
    BYTE_VALID = 1'b0;
    BYTE_OUT   = 8'h00;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (MARKER_EN && marker_due) begin
            state_n  = S_MARK0;
            marker_n = 1'b0;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_MARK0: begin
        BYTE_VALID = 1'b1;
        BYTE_OUT   = MARK0_BYTE;
        if (BYTE_READY) state_n = S_MARK1;
      end
      S_MARK1: begin
        BYTE_VALID = 1'b1;
        BYTE_OUT   = MARK1_BYTE;
        if (BYTE_READY) state_n = S_DATA;
      end
      S_DATA: begin
        BYTE_VALID = 1'b1;
        BYTE_OUT   = cur_byte;
        if (BYTE_READY) begin
          if (byte_idx == 3'd7) begin
            done_n = cur_last;
            // chain straight into the next word so there is no bubble
            if (!fifo_empty) begin
              pop = 1'b1;
              if (MARKER_EN && (marker_due || cur_last)) begin
                state_n  = S_MARK0;
                marker_n = 1'b0;
              end else begin
                state_n  = S_DATA;
                marker_n = marker_due || cur_last;
              end
            end else begin
              state_n  = S_IDLE;
              marker_n = marker_due || cur_last;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_result_serializer.sv
// Bench for fft_result_serializer: one LSB-first and one MSB-first instance
// share all inputs; a queue-based byte-stream model predicts both outputs.
module tb_fft_result_serializer;

`ifdef FRAME_MARKER_EN
  localparam bit MK = 1'b1;
`else
  localparam bit MK = 1'b0;
`endif
  localparam int HDR = MK ? 2 : 0;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] din;
  logic        din_vld, din_last, byte_rdy;
  logic        rdy_l, bvld_l, fd_l, busy_l;
  logic        rdy_m, bvld_m, fd_m, busy_m;
  logic [7:0]  bout_l, bout_m;

  int checks = 0;
  int failures = 0;

  word_t      src[$];
  int         rdy_mode;   // 0 low, 1 high, 2 toggle, 3 random
  bit         gap_en;
  logic [7:0] exp_l[$], exp_m[$], got_l[$], got_m[$];
  int         got_cyc[$], fd_cyc[$], fd_cyc_m[$], exp_fd[$], acc_cyc[$];
  int         cyc;
  bit         mdue;
  int         stall_err;
  logic       prev_stall_l, prev_stall_m;
  logic [7:0] prev_b_l, prev_b_m;

  fft_result_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
    .CLK(clk), .RST(rst_n), .FFT_DATA_IN(din), .FFT_IN_VALID(din_vld),
    .FFT_IN_TLAST(din_last), .RESUALT_READY(rdy_l), .BYTE_OUT(bout_l),
    .BYTE_VALID(bvld_l), .BYTE_READY(byte_rdy), .FRAME_DONE(fd_l), .BUSY(busy_l));

  fft_result_serializer #(.LSB_FIRST(1'b0)) dut_msb (
    .CLK(clk), .RST(rst_n), .FFT_DATA_IN(din), .FFT_IN_VALID(din_vld),
    .FFT_IN_TLAST(din_last), .RESUALT_READY(rdy_m), .BYTE_OUT(bout_m),
    .BYTE_VALID(bvld_m), .BYTE_READY(byte_rdy), .FRAME_DONE(fd_m), .BUSY(busy_m));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: the byte stream a word contributes once accepted
  function automatic void model_accept(logic [63:0] d, logic l);
    if (MK && mdue) begin
      exp_l.push_back(8'hA5); exp_l.push_back(8'h5A);
      exp_m.push_back(8'hA5); exp_m.push_back(8'h5A);
      mdue = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      exp_l.push_back(d[8*i +: 8]);
      exp_m.push_back(d[8*(7-i) +: 8]);
    end
    if (l) begin
      exp_fd.push_back(exp_l.size() - 1);
      mdue = 1'b1;
    end
  endfunction

  function automatic int stream_errs();
    int e = 0;
    if (got_l.size() != exp_l.size()) e++;
    if (got_m.size() != exp_m.size()) e++;
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++)
      if (got_l[i] !== exp_l[i]) e++;
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
      if (got_m[i] !== exp_m[i]) e++;
    return e;
  endfunction

  // FRAME_DONE must land exactly one cycle after the last byte of each frame
  function automatic int fd_errs();
    int e = 0;
    if (fd_cyc.size() != exp_fd.size()) e++;
    if (fd_cyc_m.size() != fd_cyc.size()) e++;
    for (int k = 0; k < fd_cyc.size() && k < exp_fd.size(); k++) begin
      if (exp_fd[k] >= got_cyc.size()) e++;
      else if (fd_cyc[k] != got_cyc[exp_fd[k]] + 1) e++;
      if (k < fd_cyc_m.size() && fd_cyc_m[k] != fd_cyc[k]) e++;
    end
    return e;
  endfunction

  // input driver: presents src[0], drops it once accepted
  initial begin
    din_vld = 1'b0; din = 64'h0; din_last = 1'b0; byte_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (din_vld && rdy_l && rst_n && src.size() > 0) src.delete(0);
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       byte_rdy = 1'b0;
        1:       byte_rdy = 1'b1;
        2:       byte_rdy = ~byte_rdy;
        default: byte_rdy = 1'($urandom_range(0, 1));
      endcase
      if (src.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        din_vld = 1'b1; din = src[0].data; din_last = src[0].last;
      end else begin
        din_vld = 1'b0; din = 64'h0; din_last = 1'b0;
      end
    end
  end

  // monitor: records accepts, byte transfers, frame pulses and stall stability
  initial begin
    cyc = 0; stall_err = 0; prev_stall_l = 1'b0; prev_stall_m = 1'b0;
    prev_b_l = 8'h00; prev_b_m = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (din_vld && rdy_l) begin
          model_accept(din, din_last);
          acc_cyc.push_back(cyc);
        end
        if (bvld_l && byte_rdy) begin got_l.push_back(bout_l); got_cyc.push_back(cyc); end
        if (bvld_m && byte_rdy) got_m.push_back(bout_m);
        if (fd_l) fd_cyc.push_back(cyc);
        if (fd_m) fd_cyc_m.push_back(cyc);
        if (prev_stall_l && (!bvld_l || bout_l !== prev_b_l)) stall_err++;
        if (prev_stall_m && (!bvld_m || bout_m !== prev_b_m)) stall_err++;
        prev_stall_l = bvld_l && !byte_rdy; prev_b_l = bout_l;
        prev_stall_m = bvld_m && !byte_rdy; prev_b_m = bout_m;
      end else begin
        prev_stall_l = 1'b0; prev_stall_m = 1'b0;
      end
      cyc++;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    src.delete();
    din_vld = 1'b0;
    repeat (2) @(negedge clk);
    exp_l.delete(); exp_m.delete(); got_l.delete(); got_m.delete();
    got_cyc.delete(); fd_cyc.delete(); fd_cyc_m.delete(); exp_fd.delete();
    acc_cyc.delete();
    mdue = 1'b1; stall_err = 0;
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_idle(output bit to);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(src.size() == 0 && got_l.size() >= exp_l.size() &&
                 got_m.size() >= exp_m.size() && !busy_l && !busy_m) && n < 5000);
    repeat (3) @(negedge clk);
    to = (n >= 5000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy_mode = 0; gap_en = 1'b0; mdue = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_l !== 1'b1 || rdy_m !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b/%b exp=1", rdy_l, rdy_m); end
    checks++; if (bvld_l !== 1'b0 || bvld_m !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b/%b exp=0", bvld_l, bvld_m); end
    checks++; if (bout_l !== 8'h00 || bout_m !== 8'h00) begin failures++; $display("FAIL reset_byte_out got=%h/%h exp=00", bout_l, bout_m); end
    checks++; if (fd_l !== 1'b0 || fd_m !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b/%b exp=0", fd_l, fd_m); end
    checks++; if (busy_l !== 1'b0 || busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=0", busy_l, busy_m); end
    apply_reset();
  endtask

  task automatic test_single_word();
    bit to;
    apply_reset();
    rdy_mode = 1; gap_en = 1'b0;
    src.push_back({1'b1, 64'h0807060504030201});
    wait_idle(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", to); end
    checks++; if (got_l.size() !== HDR + 8) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_l.size(), HDR + 8); end
    checks++; if (got_l[HDR] !== 8'h01 || got_l[HDR+7] !== 8'h08) begin failures++; $display("FAIL single_lsb_order got=%h..%h exp=01..08", got_l[HDR], got_l[HDR+7]); end
    checks++; if (got_m[HDR] !== 8'h08 || got_m[HDR+7] !== 8'h01) begin failures++; $display("FAIL single_msb_order got=%h..%h exp=08..01", got_m[HDR], got_m[HDR+7]); end
    checks++; if (stream_errs() !== 0) begin failures++; $display("FAIL single_stream got=%0d errors exp=0", stream_errs()); end
    checks++; if (got_cyc[0] !== acc_cyc[0] + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", got_cyc[0], acc_cyc[0] + 2); end
    checks++; if (got_cyc[HDR+7] - got_cyc[0] !== HDR + 7) begin failures++; $display("FAIL single_throughput got=%0d exp=%0d", got_cyc[HDR+7] - got_cyc[0], HDR + 7); end
    checks++; if (fd_cyc.size() !== 1 || fd_errs() !== 0) begin failures++; $display("FAIL single_frame_done got=%0d pulses exp=1", fd_cyc.size()); end
  endtask

  task automatic test_backpressure();
    bit to;
    apply_reset();
    rdy_mode = 0; gap_en = 1'b0;
    for (int i = 0; i < 3; i++) src.push_back({1'b0, {$urandom, $urandom}});
    repeat (12) @(negedge clk);
    checks++; if (acc_cyc.size() !== 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", acc_cyc.size()); end
    checks++; if (rdy_l !== 1'b0 || rdy_m !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b/%b exp=0", rdy_l, rdy_m); end
    checks++; if (acc_cyc[2] - acc_cyc[0] < 2) begin failures++; $display("FAIL bp_third_early got=%0d cycles exp>=2", acc_cyc[2] - acc_cyc[0]); end
    checks++; if (bvld_l !== 1'b1 || bout_l !== exp_l[0] || bout_m !== exp_m[0]) begin failures++; $display("FAIL bp_hold got=%b %h/%h exp=1 %h/%h", bvld_l, bout_l, bout_m, exp_l[0], exp_m[0]); end
    src.push_back({1'b1, {$urandom, $urandom}});
    repeat (6) @(negedge clk);
    checks++; if (acc_cyc.size() !== 3 || busy_l !== 1'b1) begin failures++; $display("FAIL bp_ignored got=%0d busy=%b exp=3 busy=1", acc_cyc.size(), busy_l); end
    rdy_mode = 1;
    wait_idle(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b exp=0", to); end
    checks++; if (got_l.size() !== HDR + 32 || stream_errs() !== 0) begin failures++; $display("FAIL bp_stream got=%0d bytes %0d errors exp=%0d bytes 0 errors", got_l.size(), stream_errs(), HDR + 32); end
    checks++; if (fd_errs() !== 0) begin failures++; $display("FAIL bp_frame_done got=%0d errors exp=0", fd_errs()); end
  endtask

  task automatic test_toggle();
    bit to;
    apply_reset();
    rdy_mode = 2; gap_en = 1'b0;
    src.push_back({1'b0, {$urandom, $urandom}});
    src.push_back({1'b1, {$urandom, $urandom}});
    wait_idle(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL toggle_timeout got=%b exp=0", to); end
    checks++; if (got_l.size() !== HDR + 16 || stream_errs() !== 0) begin failures++; $display("FAIL toggle_stream got=%0d bytes %0d errors exp=%0d bytes", got_l.size(), stream_errs(), HDR + 16); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL toggle_stable got=%0d exp=0", stall_err); end
    checks++; if (fd_errs() !== 0) begin failures++; $display("FAIL toggle_frame_done got=%0d errors exp=0", fd_errs()); end
  endtask

  task automatic test_two_frames();
    bit to;
    apply_reset();
    rdy_mode = 1; gap_en = 1'b0;
    src.push_back({1'b1, {$urandom, $urandom}});
    src.push_back({1'b1, {$urandom, $urandom}});
    wait_idle(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL frames_timeout got=%b exp=0", to); end
    checks++; if (got_l.size() !== 2 * HDR + 16 || stream_errs() !== 0) begin failures++; $display("FAIL frames_stream got=%0d bytes %0d errors exp=%0d bytes", got_l.size(), stream_errs(), 2 * HDR + 16); end
    checks++; if (fd_cyc.size() !== 2 || fd_errs() !== 0) begin failures++; $display("FAIL frames_done got=%0d pulses exp=2", fd_cyc.size()); end
  endtask

  task automatic test_mid_reset();
    bit to;
    int n = 0;
    apply_reset();
    rdy_mode = 1; gap_en = 1'b0;
    src.push_back({1'b0, {$urandom, $urandom}});
    src.push_back({1'b1, {$urandom, $urandom}});
    while (got_l.size() < HDR + 3 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin failures++; $display("FAIL midrst_wait got=%0d cycles exp<200", n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bvld_l !== 1'b0 || bvld_m !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b/%b exp=0", bvld_l, bvld_m); end
    checks++; if (rdy_l !== 1'b1 || busy_l !== 1'b0 || busy_m !== 1'b0) begin failures++; $display("FAIL midrst_ready_busy got=%b %b/%b exp=1 0/0", rdy_l, busy_l, busy_m); end
    apply_reset();
    rdy_mode = 1;
    src.push_back({1'b1, {$urandom, $urandom}});
    wait_idle(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL midrst_timeout got=%b exp=0", to); end
    checks++; if (got_l.size() !== HDR + 8 || stream_errs() !== 0) begin failures++; $display("FAIL midrst_stream got=%0d bytes %0d errors exp=%0d bytes", got_l.size(), stream_errs(), HDR + 8); end
    checks++; if (fd_cyc.size() !== 1) begin failures++; $display("FAIL midrst_frame_done got=%0d exp=1", fd_cyc.size()); end
  endtask

  task automatic test_random();
    bit to;
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      rdy_mode = (r == 0) ? 3 : 1; gap_en = 1'b1;
      for (int i = 0; i < 24; i++)
        src.push_back({(i == 23) || ($urandom_range(0, 2) == 0), {$urandom, $urandom}});
      wait_idle(to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout got=%b exp=0", r, to); end
      checks++; if (stream_errs() !== 0) begin failures++; $display("FAIL rand%0d_stream got=%0d errors exp=0", r, stream_errs()); end
      checks++; if (fd_errs() !== 0) begin failures++; $display("FAIL rand%0d_frame_done got=%0d errors exp=0", r, fd_errs()); end
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL rand%0d_stable got=%0d exp=0", r, stall_err); end
    end
  endtask

  initial begin
    rdy_mode = 0; gap_en = 1'b0; rst_n = 1'b0; mdue = 1'b1;
    test_reset();
    test_single_word();
    test_backpressure();
    test_toggle();
    test_two_frames();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
